// File: rtl/uart_16550_rx_fifo_trig.sv
// ---------------------------------------------------------------------------
// uart_16550_rx_fifo_trig
//
// Receive FIFO for a 16550-compatible UART. It sits between the Rx
// deserialiser and the Wishbone register file (RBR / LSR / IIR).
// Each entry holds one character plus its parity, framing and break status
// bits. The storage is built from flops.
//
// The block adds the usual 16550 receive features:
//   - a selectable trigger level,
//   - a character-timeout interrupt,
//   - a sticky overrun flag,
//   - the LSR "error in FIFO" flag.
// With the FIFO disabled it behaves as a 16450: a single holding register.
//
// Ports
//   WBs_CLK_i, WBs_RST_i    clock and synchronous active-high reset
//   Rx_FIFO_Enable_i        1 = FIFO mode (DEPTH entries), 0 = 16450 mode
//   Rx_FIFO_Flush_i         flush pulse (FCR bit 1)
//   Rx_Trigger_Sel_i        trigger level select (FCR bits 7:6)
//   Rx_FIFO_Push_i          write character + status bits
//   Rx_FIFO_DAT_i, Rx_Parity_Error_i, Rx_Framing_Error_i,
//   Rx_Break_Interrupt_i    the character and its status bits
//   Rx_Char_Tick_i          one pulse per character time
//   Rx_FIFO_Pop_i           remove the head character (RBR read)
//   Rx_Overrun_Clr_i        clear the overrun flag (LSR read)
//   Rx_FIFO_DAT_o, Rx_*_o   head character and its status (0 when empty)
//   Rx_FIFO_Level_o         number of entries held
//   Rx_FIFO_Empty_o, Rx_FIFO_Full_o
//   Rx_Overrun_o            sticky overrun
//   Rx_Error_In_FIFO_o      some stored entry has a status bit set
//   Rx_Trigger_o            level has reached the selected threshold
//   Rx_Timeout_o            character timeout interrupt
// ---------------------------------------------------------------------------
module uart_16550_rx_fifo_trig #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                  WBs_CLK_i,
  input  logic                  WBs_RST_i,
  input  logic                  Rx_FIFO_Enable_i,
  input  logic                  Rx_FIFO_Flush_i,
  input  logic [1:0]            Rx_Trigger_Sel_i,
  input  logic                  Rx_FIFO_Push_i,
  input  logic [DATA_WIDTH-1:0] Rx_FIFO_DAT_i,
  input  logic                  Rx_Parity_Error_i,
  input  logic                  Rx_Framing_Error_i,
  input  logic                  Rx_Break_Interrupt_i,
  input  logic                  Rx_Char_Tick_i,
  input  logic                  Rx_FIFO_Pop_i,
  input  logic                  Rx_Overrun_Clr_i,
  output logic [DATA_WIDTH-1:0] Rx_FIFO_DAT_o,
  output logic                  Rx_Parity_Error_o,
  output logic                  Rx_Framing_Error_o,
  output logic                  Rx_Break_Interrupt_o,
  output logic [ADDR_WIDTH:0]   Rx_FIFO_Level_o,
  output logic                  Rx_FIFO_Empty_o,
  output logic                  Rx_FIFO_Full_o,
  output logic                  Rx_Overrun_o,
  output logic                  Rx_Error_In_FIFO_o,
  output logic                  Rx_Trigger_o,
  output logic                  Rx_Timeout_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;
  localparam int EW    = DATA_WIDTH + 3;
  localparam int TW    = $clog2(TIMEOUT_CHARS + 1);

  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_L    = LW'(1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CHARS);

  // Each entry is stored as {break, framing, parity, data}.
  logic [EW-1:0]         mem [DEPTH];

  logic                  enable_q;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [LW-1:0]         level;
  logic [LW-1:0]         err_cnt;
  logic [TW-1:0]         to_cnt;
  logic                  empty_q;

  logic                  flush;
  logic [LW-1:0]         cap;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  drop;
  logic [EW-1:0]         head;
  logic                  push_err;
  logic                  head_err;
  logic [LW-1:0]         level_next;
  logic [LW-1:0]         err_next;
  logic [TW-1:0]         to_next;
  logic [LW-1:0]         cap_next;
  logic [LW-1:0]         thresh_next;
  logic [ADDR_WIDTH-1:0] ptr_step;

  // A mode change empties the FIFO in the same way as an explicit flush.
  // The capacity follows the registered mode, so the new capacity takes
  // effect together with the flush that the mode change causes.
  always_comb begin
    flush    = Rx_FIFO_Flush_i | (Rx_FIFO_Enable_i != enable_q);
    cap      = enable_q ? DEPTH_L : ONE_L;
    cap_next = Rx_FIFO_Enable_i ? DEPTH_L : ONE_L;
    ptr_step = enable_q ? ADDR_WIDTH'(1) : '0;
  end

  // Accept or drop the push and the pop.
  // A push into a full FIFO succeeds when a pop frees a slot in the same
  // cycle. A pop on an empty FIFO does nothing, so push+pop at level 0
  // degenerates to a plain push. A flush overrides everything.
  always_comb begin
    head     = mem[rptr];
    push_err = Rx_Parity_Error_i | Rx_Framing_Error_i | Rx_Break_Interrupt_i;
    head_err = |head[EW-1:DATA_WIDTH];
    push_ok  = Rx_FIFO_Push_i & ~flush & ((level < cap) | Rx_FIFO_Pop_i);
    pop_ok   = Rx_FIFO_Pop_i & ~flush & (level != '0);
    drop     = Rx_FIFO_Push_i & ~flush & (level == cap) & ~Rx_FIFO_Pop_i;
  end

  // Next-state values for the level, the error count and the timeout
  // counter. The registered status outputs are derived from these next
  // values, so each flag changes on the same edge as the count behind it.
  always_comb begin
    level_next = level;
    err_next   = err_cnt;
    to_next    = to_cnt;
    if (flush) begin
      level_next = '0;
      err_next   = '0;
      to_next    = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   level_next = level + ONE_L;
        2'b01:   level_next = level - ONE_L;
        default: level_next = level;
      endcase
      case ({push_ok & push_err, pop_ok & head_err})
        2'b10:   err_next = err_cnt + ONE_L;
        2'b01:   err_next = err_cnt - ONE_L;
        default: err_next = err_cnt;
      endcase
      // Any FIFO activity restarts the timeout. An empty FIFO also holds
      // the counter at zero. Otherwise the counter counts character
      // times and saturates at the limit.
      if (Rx_FIFO_Push_i || Rx_FIFO_Pop_i || level == '0)
        to_next = '0;
      else if (Rx_Char_Tick_i && to_cnt != TO_MAX)
        to_next = to_cnt + TW'(1);
    end
  end

  // Trigger threshold for the mode and selection in force after this edge.
  // In 16450 mode the threshold is always 1.
  always_comb begin
    thresh_next = ONE_L;
    if (Rx_FIFO_Enable_i) begin
      case (Rx_Trigger_Sel_i)
        2'b00:   thresh_next = ONE_L;
        2'b01:   thresh_next = LW'(DEPTH / 4);
        2'b10:   thresh_next = LW'(DEPTH / 2);
        default: thresh_next = LW'(DEPTH - 2);
      endcase
    end
  end

  // Character storage. It has no reset: an entry is only visible after it
  // has been written, because the head outputs are gated by Empty.
  always_ff @(posedge WBs_CLK_i) begin
    if (push_ok)
      mem[wptr] <= {Rx_Break_Interrupt_i, Rx_Framing_Error_i,
                    Rx_Parity_Error_i, Rx_FIFO_DAT_i};
  end

  // Pointers, counters and the registered status flags.
  // Overrun survives a flush and is cleared only by reset or by an LSR read.
  // If a drop happens in the same cycle as the LSR read, the drop wins.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      enable_q           <= Rx_FIFO_Enable_i;
      wptr               <= '0;
      rptr               <= '0;
      level              <= '0;
      err_cnt            <= '0;
      to_cnt             <= '0;
      empty_q            <= 1'b1;
      Rx_FIFO_Full_o     <= 1'b0;
      Rx_Overrun_o       <= 1'b0;
      Rx_Error_In_FIFO_o <= 1'b0;
      Rx_Trigger_o       <= 1'b0;
      Rx_Timeout_o       <= 1'b0;
    end else begin
      enable_q <= Rx_FIFO_Enable_i;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push_ok) wptr <= wptr + ptr_step;
        if (pop_ok)  rptr <= rptr + ptr_step;
      end
      level              <= level_next;
      err_cnt            <= err_next;
      to_cnt             <= to_next;
      empty_q            <= (level_next == '0);
      Rx_FIFO_Full_o     <= (level_next == cap_next);
      Rx_Error_In_FIFO_o <= (err_next != '0);
      Rx_Trigger_o       <= (level_next >= thresh_next);
      Rx_Timeout_o       <= (to_next == TO_MAX) && (level_next != '0);
      if (drop)
        Rx_Overrun_o <= 1'b1;
      else if (Rx_Overrun_Clr_i)
        Rx_Overrun_o <= 1'b0;
    end
  end

  // Head outputs are a direct read of the read pointer, forced to zero
  // while the FIFO is empty.
  always_comb begin
    Rx_FIFO_Level_o      = level;
    Rx_FIFO_Empty_o      = empty_q;
    Rx_FIFO_DAT_o        = empty_q ? '0   : head[DATA_WIDTH-1:0];
    Rx_Parity_Error_o    = empty_q ? 1'b0 : head[DATA_WIDTH];
    Rx_Framing_Error_o   = empty_q ? 1'b0 : head[DATA_WIDTH+1];
    Rx_Break_Interrupt_o = empty_q ? 1'b0 : head[DATA_WIDTH+2];
  end

endmodule
